// File: rtl/alu_pkg.sv
// Shared opcode encodings and instruction field widths for the ALU issue stage.
package alu_pkg;

  localparam int OPC_W = 3;
  localparam int IMM_W = 16;

  localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPC_W-1:0] OP_MUL = 3'b010;
  localparam logic [OPC_W-1:0] OP_AND = 3'b011;
  localparam logic [OPC_W-1:0] OP_OR  = 3'b100;

  // Highest opcode the ALU defines; anything above is undefined.
  localparam logic [OPC_W-1:0] OP_MAX = OP_OR;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake, ALU operand/result and writeback bus of the issue stage.
interface alu_issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  in_opcode;
  logic [ADDR_W-1:0] in_rs;
  logic [ADDR_W-1:0] in_rt;
  logic [ADDR_W-1:0] in_rd;
  logic [IMM_W-1:0]  in_imm;
  logic              in_use_imm;
  logic              hold;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              illegal_op;
  logic [CNT_W-1:0]  retire_cnt;

  // Environment side: decoder, hazard control and the external ALU.
  modport master (
    output in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm, in_use_imm, hold, alu_result,
    input  in_ready, alu_a, alu_b, alu_opcode, wb_valid, wb_addr, wb_data, illegal_op, retire_cnt
  );

  // Issue stage side.
  modport slave (
    input  in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm, in_use_imm, hold, alu_result,
    output in_ready, alu_a, alu_b, alu_opcode, wb_valid, wb_addr, wb_data, illegal_op, retire_cnt
  );

endinterface

// File: rtl/alu_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module alu_regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [REG_CNT];

  // Clear every register on reset; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue (with forwarding), registered EX stage, WB register and retire counter around an external ALU.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  alu_issue_stage_if.slave bus
);

  logic              w_fire;
  logic              w_legal;
  logic              w_retire;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_rt;
  logic [DATA_W-1:0] w_op_b;

  logic              r_ex_vld_p1;
  logic [ADDR_W-1:0] r_ex_rd_p1;
  logic [DATA_W-1:0] r_alu_a_p1;
  logic [DATA_W-1:0] r_alu_b_p1;
  logic [OPC_W-1:0]  r_alu_op_p1;
  logic              r_illegal_p1;
  logic              r_wb_vld_p2;
  logic [ADDR_W-1:0] r_wb_addr_p2;
  logic [DATA_W-1:0] r_wb_data_p2;
  logic [CNT_W-1:0]  r_retire_cnt;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  assign bus.in_ready = ~bus.hold & ~rst;
  assign w_fire       = bus.in_valid & bus.in_ready;
  assign w_legal      = op_legal(bus.in_opcode);
  // A retiring write also covers the same-cycle read of that register through the WB forward.
  assign w_retire     = r_wb_vld_p2 & ~bus.hold;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_retire),
    .i_waddr  (r_wb_addr_p2),
    .i_wdata  (r_wb_data_p2),
    .i_raddr_a(bus.in_rs),
    .i_raddr_b(bus.in_rt),
    .o_rdata_a(w_rf_a),
    .o_rdata_b(w_rf_b)
  );

  // Source A select: r0, then youngest in-flight result, then WB, then register file.
  always_comb begin
    w_op_a = w_rf_a;
    if (bus.in_rs == '0)                                 w_op_a = '0;
    else if (r_ex_vld_p1 && (r_ex_rd_p1 == bus.in_rs))   w_op_a = bus.alu_result;
    else if (r_wb_vld_p2 && (r_wb_addr_p2 == bus.in_rs)) w_op_a = r_wb_data_p2;
  end

  // Source B select, same priority as A, with the immediate overriding the register.
  always_comb begin
    w_op_rt = w_rf_b;
    if (bus.in_rt == '0)                                 w_op_rt = '0;
    else if (r_ex_vld_p1 && (r_ex_rd_p1 == bus.in_rt))   w_op_rt = bus.alu_result;
    else if (r_wb_vld_p2 && (r_wb_addr_p2 == bus.in_rt)) w_op_rt = r_wb_data_p2;
    w_op_b = bus.in_use_imm ? sext_imm(bus.in_imm) : w_op_rt;
  end

  // ---- EX stage (p1): illegal opcodes become bubbles and never load the ALU operands ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_vld_p1 <= 1'b0;
      r_ex_rd_p1  <= '0;
      r_alu_a_p1  <= '0;
      r_alu_b_p1  <= '0;
      r_alu_op_p1 <= '0;
    end else if (!bus.hold) begin
      r_ex_vld_p1 <= w_fire & w_legal;
      if (w_fire && w_legal) begin
        r_ex_rd_p1  <= bus.in_rd;
        r_alu_a_p1  <= w_op_a;
        r_alu_b_p1  <= w_op_b;
        r_alu_op_p1 <= bus.in_opcode;
      end
    end
  end

  // One-cycle flag for an accepted undefined opcode.
  always_ff @(posedge clk) begin
    if (rst) r_illegal_p1 <= 1'b0;
    else     r_illegal_p1 <= w_fire & ~w_legal;
  end

  // ---- WB stage (p2): capture the ALU result, frozen while held ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_vld_p2  <= 1'b0;
      r_wb_addr_p2 <= '0;
      r_wb_data_p2 <= '0;
    end else if (!bus.hold) begin
      r_wb_vld_p2  <= r_ex_vld_p1;
      r_wb_addr_p2 <= r_ex_rd_p1;
      r_wb_data_p2 <= bus.alu_result;
    end
  end

  // Count every retiring result, including writes to r0 that store nothing.
  always_ff @(posedge clk) begin
    if (rst)           r_retire_cnt <= '0;
    else if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
  end

  assign bus.alu_a      = r_alu_a_p1;
  assign bus.alu_b      = r_alu_b_p1;
  assign bus.alu_opcode = r_alu_op_p1;
  assign bus.wb_valid   = r_wb_vld_p2;
  assign bus.wb_addr    = r_wb_addr_p2;
  assign bus.wb_data    = r_wb_data_p2;
  assign bus.illegal_op = r_illegal_p1;
  assign bus.retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed test of alu_issue_stage with a behavioural ALU closing the loop.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_issue_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();

  alu_issue_stage #(
    .DATA_W (32),
    .REG_CNT(32),
    .ADDR_W (5),
    .CNT_W  (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU as the parent would provide it.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_opcode)
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_MUL:  bus.alu_result = bus.alu_a * bus.alu_b;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic use_imm);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = op;
    bus.in_rs      = rs;
    bus.in_rt      = rt;
    bus.in_rd      = rd;
    bus.in_imm     = imm;
    bus.in_use_imm = use_imm;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.hold       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_opcode  = '0;
    bus.in_rs      = '0;
    bus.in_rt      = '0;
    bus.in_rd      = '0;
    bus.in_imm     = '0;
    bus.in_use_imm = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_retire", 32'(bus.retire_cnt), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // ADD r1 = r0 + 5
    issue(OP_ADD, 5'd0, 5'd0, 5'd1, 16'd5, 1'b1);
    tick();
    chk("t1_alu_a", bus.alu_a, 32'd0);
    chk("t1_alu_b", bus.alu_b, 32'd5);
    chk("t1_alu_op", 32'(bus.alu_opcode), 32'(OP_ADD));
    idle();
    tick();
    chk("t1_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("t1_wb_addr", 32'(bus.wb_addr), 32'd1);
    chk("t1_wb_data", bus.wb_data, 32'd5);
    tick();
    chk("t1_retire", 32'(bus.retire_cnt), 32'd1);
    chk("t1_wb_idle", 32'(bus.wb_valid), 32'd0);

    // ADD r1 = 7, then dependent SUB r2 = r1 - 2 back to back
    issue(OP_ADD, 5'd0, 5'd0, 5'd1, 16'd7, 1'b1);
    tick();
    issue(OP_SUB, 5'd1, 5'd0, 5'd2, 16'd2, 1'b1);
    tick();
    chk("t2_ex_fwd_a", bus.alu_a, 32'd7);
    chk("t2_alu_b", bus.alu_b, 32'd2);
    chk("t2_alu_op", 32'(bus.alu_opcode), 32'(OP_SUB));
    idle();
    tick();
    chk("t2_wb_addr", 32'(bus.wb_addr), 32'd2);
    chk("t2_wb_data", bus.wb_data, 32'd5);
    tick();
    chk("t2_retire", 32'(bus.retire_cnt), 32'd3);

    // MUL r3 = r1 * sext(0xFFFF)
    issue(OP_MUL, 5'd1, 5'd0, 5'd3, 16'hFFFF, 1'b1);
    tick();
    chk("t3_alu_a", bus.alu_a, 32'd7);
    chk("t3_sext_b", bus.alu_b, 32'hFFFF_FFFF);
    idle();
    tick();
    chk("t3_wb_data", bus.wb_data, 32'hFFFF_FFF9);
    tick();
    chk("t3_retire", 32'(bus.retire_cnt), 32'd4);

    // Undefined opcode 110
    issue(3'b110, 5'd1, 5'd0, 5'd4, 16'd1, 1'b1);
    tick();
    chk("t4_illegal_pulse", 32'(bus.illegal_op), 32'd1);
    chk("t4_op_not_loaded", 32'(bus.alu_opcode), 32'(OP_MUL));
    idle();
    tick();
    chk("t4_illegal_drop", 32'(bus.illegal_op), 32'd0);
    chk("t4_no_wb", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("t4_no_wb2", 32'(bus.wb_valid), 32'd0);
    chk("t4_retire", 32'(bus.retire_cnt), 32'd4);

    // WB forward coinciding with the register file write: r5 = r1 + 1, gap, r6 = r5 | 0x10
    issue(OP_ADD, 5'd1, 5'd0, 5'd5, 16'd1, 1'b1);
    tick();
    idle();
    tick();
    issue(OP_OR, 5'd5, 5'd0, 5'd6, 16'h0010, 1'b1);
    tick();
    chk("t5_wb_fwd_a", bus.alu_a, 32'd8);
    idle();
    tick();
    chk("t5_or_data", bus.wb_data, 32'h18);
    tick();
    chk("t5_retire", 32'(bus.retire_cnt), 32'd6);

    // Hold for 3 cycles with r7 = r1 + 3 in EX and another request pending
    issue(OP_ADD, 5'd1, 5'd0, 5'd7, 16'd3, 1'b1);
    tick();
    bus.hold = 1'b1;
    issue(OP_ADD, 5'd0, 5'd0, 5'd8, 16'd100, 1'b1);
    #1;
    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_alu_a", bus.alu_a, 32'd7);
      chk("hold_alu_b", bus.alu_b, 32'd3);
      chk("hold_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("hold_retire", 32'(bus.retire_cnt), 32'd6);
    end
    bus.hold = 1'b0;
    idle();
    tick();
    chk("rel_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("rel_wb_addr", 32'(bus.wb_addr), 32'd7);
    chk("rel_wb_data", bus.wb_data, 32'd10);
    chk("rel_alu_b_kept", bus.alu_b, 32'd3);
    tick();
    chk("rel_retire", 32'(bus.retire_cnt), 32'd7);
    tick();
    chk("rel_retire_once", 32'(bus.retire_cnt), 32'd7);

    // Write r0 = 9, then read r0 while that write is still in flight
    issue(OP_ADD, 5'd0, 5'd0, 5'd0, 16'd9, 1'b1);
    tick();
    issue(OP_ADD, 5'd0, 5'd0, 5'd9, 16'd1, 1'b1);
    tick();
    chk("r0_read_zero", bus.alu_a, 32'd0);
    chk("r0_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("r0_wb_data", bus.wb_data, 32'd9);
    idle();
    tick();
    chk("r9_wb_data", bus.wb_data, 32'd1);
    tick();
    chk("r0_retire", 32'(bus.retire_cnt), 32'd9);

    // Reset with r10 = r1 + 1 in EX
    issue(OP_ADD, 5'd1, 5'd0, 5'd10, 16'd1, 1'b1);
    tick();
    chk("pre_rst_alu_a", bus.alu_a, 32'd7);
    idle();
    rst = 1'b1;
    tick();
    chk("mid_rst_alu_a", bus.alu_a, 32'd0);
    chk("mid_rst_alu_b", bus.alu_b, 32'd0);
    chk("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("mid_rst_wb_data", bus.wb_data, 32'd0);
    chk("mid_rst_retire", 32'(bus.retire_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_no_wb", 32'(bus.wb_valid), 32'd0);
    issue(OP_ADD, 5'd1, 5'd0, 5'd11, 16'd0, 1'b1);
    tick();
    chk("post_rst_r1_clear", bus.alu_a, 32'd0);
    idle();
    tick();
    tick();
    chk("post_rst_retire", 32'(bus.retire_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
